// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction decode controller: FSM states,
// data-processing opcodes and instruction field bit positions.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } ctrl_state_t;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_EOR = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8;
    localparam logic [3:0] OP_TEQ = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;
    localparam logic [3:0] OP_BIC = 4'd14;
    localparam logic [3:0] OP_MVN = 4'd15;

    localparam int unsigned CLS_HI   = 27;
    localparam int unsigned CLS_LO   = 26;
    localparam int unsigned BIT_I    = 25;
    localparam int unsigned OP_HI    = 24;
    localparam int unsigned OP_LO    = 21;
    localparam int unsigned BIT_S    = 20;
    localparam int unsigned RN_HI    = 19;
    localparam int unsigned RN_LO    = 16;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 12;
    localparam int unsigned ROT_HI   = 11;
    localparam int unsigned ROT_LO   = 8;
    localparam int unsigned IMM8_HI  = 7;
    localparam int unsigned IMM8_LO  = 0;
    localparam int unsigned SAMT_HI  = 11;
    localparam int unsigned SAMT_LO  = 7;
    localparam int unsigned STYP_HI  = 6;
    localparam int unsigned STYP_LO  = 5;
    localparam int unsigned BIT_RSH  = 4;
    localparam int unsigned RM_HI    = 3;
    localparam int unsigned RM_LO    = 0;

    // Compare-class ops only set flags; they never write the register file.
    function automatic logic is_cmp_op(input logic [3:0] op);
        return (op >= OP_TST) && (op <= OP_CMN);
    endfunction

endpackage

// File: rtl/dp_operand2_dec.sv
// Operand-2 field decode: rotated 8-bit immediate and register-shift fields
// extracted from the low 12 bits of a data-processing instruction.
module dp_operand2_dec
    import ctrl_pkg::*;
(
    input  logic [11:0] i_op2,
    output logic [31:0] o_imm32,
    output logic [3:0]  o_rm,
    output logic [1:0]  o_shift_type,
    output logic [4:0]  o_shift_amt,
    output logic        o_reg_shift
);

    logic [31:0] w_imm8;
    logic [4:0]  w_rot;
    logic [5:0]  w_lrot;

    assign w_imm8 = {24'd0, i_op2[IMM8_HI:IMM8_LO]};
    assign w_rot  = {i_op2[ROT_HI:ROT_LO], 1'b0};
    // A left shift of 32 yields zero, so a rotate of 0 falls out naturally.
    assign w_lrot = 6'd32 - {1'b0, w_rot};

    assign o_imm32      = (w_imm8 >> w_rot) | (w_imm8 << w_lrot);
    assign o_rm         = i_op2[RM_HI:RM_LO];
    assign o_shift_type = i_op2[STYP_HI:STYP_LO];
    assign o_shift_amt  = i_op2[SAMT_HI:SAMT_LO];
    assign o_reg_shift  = i_op2[BIT_RSH];

endmodule

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback controller for data-processing
// instructions. Optional performance counters enabled by CTRL_PERF_CNT_EN.
module instr_decode_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR,
    input  logic        W_IR_valid,
    input  logic [3:0]  alu_nzcv,
    output logic        write_ir,
    output logic        write_pc,
    output logic [3:0]  NZCV,
    output logic [3:0]  rn_addr,
    output logic [3:0]  rd_addr,
    output logic [3:0]  rm_addr,
    output logic [3:0]  alu_op,
    output logic [1:0]  shift_type,
    output logic [4:0]  shift_amt,
    output logic        imm_sel,
    output logic [31:0] imm32,
    output logic        write_reg,
    output logic [31:0] retired_cnt,
    output logic [31:0] annulled_cnt
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    ctrl_state_t r_state, w_next;
    logic        r_fetch_ok, r_s, r_imm_sel;
    logic [3:0]  r_nzcv, r_rn, r_rd, r_rm, r_op, r_cnt;
    logic [1:0]  r_shift_type;
    logic [4:0]  r_shift_amt;
    logic [31:0] r_imm32;

    logic [31:0] w_imm32;
    logic [3:0]  w_rm;
    logic [1:0]  w_shift_type;
    logic [4:0]  w_shift_amt;
    logic        w_reg_shift, w_nop, w_fetch;
    logic        w_unused_cond;

    dp_operand2_dec u_op2 (
        .i_op2       (IR[11:0]),
        .o_imm32     (w_imm32),
        .o_rm        (w_rm),
        .o_shift_type(w_shift_type),
        .o_shift_amt (w_shift_amt),
        .o_reg_shift (w_reg_shift)
    );

    // Condition field is resolved in the fetch stage and arrives via W_IR_valid.
    assign w_unused_cond = ^IR[31:28];
    assign w_nop   = (IR[CLS_HI:CLS_LO] != 2'b00) || (!IR[BIT_I] && w_reg_shift);
    assign w_fetch = (r_state == S_FETCH);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = r_fetch_ok ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_nop ? S_FETCH : S_EXEC;
            S_EXEC:   w_next = (r_cnt == 4'd0) ? S_WB : S_EXEC;
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Sampled on the same falling edge that loads IR in the fetch stage.
    always_ff @(negedge clk or posedge rst) begin
        if (rst)          r_fetch_ok <= 1'b0;
        else if (w_fetch) r_fetch_ok <= W_IR_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rn         <= '0;
            r_rd         <= '0;
            r_rm         <= '0;
            r_op         <= '0;
            r_s          <= 1'b0;
            r_imm_sel    <= 1'b0;
            r_imm32      <= '0;
            r_shift_type <= '0;
            r_shift_amt  <= '0;
            r_cnt        <= '0;
            r_nzcv       <= '0;
        end else begin
            if (r_state == S_DECODE) begin
                r_rn      <= IR[RN_HI:RN_LO];
                r_rd      <= IR[RD_HI:RD_LO];
                r_op      <= IR[OP_HI:OP_LO];
                r_s       <= IR[BIT_S];
                r_imm_sel <= IR[BIT_I];
                r_cnt     <= EXEC_LOAD;
                if (IR[BIT_I]) begin
                    r_imm32 <= w_imm32;
                end else begin
                    r_rm         <= w_rm;
                    r_shift_type <= w_shift_type;
                    r_shift_amt  <= w_shift_amt;
                end
            end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_WB && (r_s || is_cmp_op(r_op)))
                r_nzcv <= alu_nzcv;
        end
    end

    assign write_ir   = w_fetch;
    assign write_pc   = w_fetch;
    assign write_reg  = (r_state == S_WB) && !is_cmp_op(r_op);
    assign NZCV       = r_nzcv;
    assign rn_addr    = r_rn;
    assign rd_addr    = r_rd;
    assign rm_addr    = r_rm;
    assign alu_op     = r_op;
    assign shift_type = r_shift_type;
    assign shift_amt  = r_shift_amt;
    assign imm_sel    = r_imm_sel;
    assign imm32      = r_imm32;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_retired, r_annulled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired  <= '0;
            r_annulled <= '0;
        end else begin
            if (r_state == S_WB || (r_state == S_DECODE && w_nop))
                r_retired <= r_retired + 32'd1;
            if (w_fetch && !r_fetch_ok)
                r_annulled <= r_annulled + 32'd1;
        end
    end

    assign retired_cnt  = r_retired;
    assign annulled_cnt = r_annulled;
`else
    assign retired_cnt  = '0;
    assign annulled_cnt = '0;
`endif

endmodule

// File: doc/instr_decode_ctrl.md
INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, giving the number of execute cycles per instruction (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: system clock; the FSM and all registers advance on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port IR, input, 32: instruction register from the fetch stage; it changes on the falling edge.
REQ-005 SHALL have port W_IR_valid, input, 1: the fetch stage's condition-pass AND write_ir.
REQ-006 SHALL have port alu_nzcv, input, 4: flags produced by the ALU, bit order {N,Z,C,V}.
REQ-007 SHALL have ports write_ir and write_pc, output, 1 each: fetch strobes.
REQ-008 SHALL have port NZCV, output, 4: architectural flag register, fed back to the fetch stage.
REQ-009 SHALL have ports rn_addr, rd_addr and rm_addr, output, 4 each: register-file addresses.
REQ-010 SHALL have ports alu_op (output, 4), shift_type (output, 2) and shift_amt (output, 5).
REQ-011 SHALL have ports imm_sel (output, 1) and imm32 (output, 32): selects and supplies the rotated immediate.
REQ-012 SHALL have port write_reg, output, 1: register-file write strobe.
REQ-013 SHALL have ports retired_cnt and annulled_cnt, output, 32 each: performance counters.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC and WB.
REQ-015 SHALL move IDLE->FETCH unconditionally after one cycle.
REQ-016 SHALL assert write_ir=write_pc=1 in FETCH only; both strobes are decoded from the state register alone.
REQ-017 SHALL capture W_IR_valid into fetch_ok on the falling edge while write_ir=1, which is the same edge on which IR loads.
REQ-018 FETCH transitions:
- fetch_ok=0: FETCH->FETCH (instruction annulled; PC still advances).
- fetch_ok=1: FETCH->DECODE.
REQ-019 DECODE SHALL register IR fields as follows:
- I=IR[25], op=IR[24:21], S=IR[20].
- rn_addr=IR[19:16], rd_addr=IR[15:12].
- I=1: imm32 = zero-extended IR[7:0] rotated right by 2*IR[11:8]; imm_sel=1.
- I=0: rm_addr=IR[3:0], shift_type=IR[6:5], shift_amt=IR[11:7], imm_sel=0.
REQ-020 SHALL treat IR[27:26]!=00, or I=0 with IR[4]=1, as a NOP: DECODE->FETCH, no write_reg, no flag update.
REQ-021 SHALL go DECODE->EXEC otherwise; EXEC holds alu_op=op for exactly EXEC_CYCLES cycles using a down-counter, then moves to WB.
REQ-022 WB SHALL last one cycle, then go to FETCH:
- write_reg=1 unless op is 8..11 (TST, TEQ, CMP, CMN).
- NZCV<=alu_nzcv on the WB clock edge if S=1 or op is 8..11; otherwise NZCV holds.
REQ-023 SHALL give a valid instruction a latency of 3+EXEC_CYCLES cycles from FETCH entry to FETCH re-entry; an annulled fetch costs 1 cycle.
REQ-024 SHALL hold all decoded field outputs stable from DECODE exit through WB.

Reset
REQ-025 On rst SHALL immediately set the following, regardless of state:
- state=IDLE, fetch_ok=0, NZCV=0.
- All address, field and imm outputs = 0; write_ir=write_pc=write_reg=0.
- Both counters = 0.
REQ-026 SHALL treat rst asserted mid-instruction as aborting that instruction: no write_reg, no NZCV update.

Configuration
REQ-027 With CTRL_PERF_CNT_EN defined, SHALL increment retired_cnt on each WB and on each NOP exit from DECODE, and annulled_cnt on each FETCH->FETCH transition; both counters wrap modulo 2^32.
REQ-028 Without CTRL_PERF_CNT_EN, SHALL have no counters instantiated and SHALL tie retired_cnt and annulled_cnt to 0.

Structure
REQ-029 SHALL place the state encoding, data-processing opcode constants (AND..MVN, 0..15) and the field bit positions in shared package ctrl_pkg.
REQ-030 SHALL implement operand-2 decode (immediate rotate and shift-field extraction) in the sub-module dp_operand2_dec.

Verification
REQ-031 IR=0xE0812003 (ADD R2,R1,R3), EXEC_CYCLES=1 -> rn=1, rd=2, rm=3, imm_sel=0, alu_op=4; write_reg pulses in the 4th cycle; NZCV unchanged.
REQ-032 IR=0xE3A004FF (MOV R0,#0xFF000000) -> imm_sel=1, imm32=0xFF000000, alu_op=13, write_reg=1.
REQ-033 IR=0xE1530004 (CMP R3,R4), alu_nzcv=4'b0110 -> write_reg stays 0; NZCV=0110 after WB.
REQ-034 IR=0x00812003 (ADDEQ) with NZCV.Z=0, giving W_IR_valid=0 -> FETCH repeats, no DECODE, annulled_cnt+1 (macro on).
REQ-035 rst asserted during EXEC of IR=0xE2531001 (SUBS) -> state=IDLE at once, NZCV=0, no write_reg pulse.
REQ-036 EXEC_CYCLES=3, IR=0xE0812003 -> EXEC lasts exactly 3 cycles; FETCH re-entered 6 cycles after the first FETCH.
